mdu_hilo: RTL
=============

# mdu_hilo

Iterative multiply/divide unit with the architectural HI/LO register pair for the single-cycle MIPS datapath. It consumes the two register-file read operands (rs on `A`, rt on `B`) for MULT/MULTU/DIV/DIVU and runs a shift-add or restoring-divide sequence over multiple cycles. It raises `Busy` so the control unit can stall instruction fetch, and it exposes `Hi`/`Lo` for MFHI/MFLO, whose result goes to the register-file write port. MTHI/MTLO write the pair directly.

## Interface
Parameters:
- `WIDTH`, 32, operand and HI/LO width. The iteration count equals `WIDTH`, and the counter width is clog2(`WIDTH`)+1.

Ports:
- `Clock`  in  1  rising-edge clock.
- `Resetn`  in  1  asynchronous, active-low reset.
- `Start`  in  1  launch request, sampled only in IDLE.
- `Op`  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `A`  in  WIDTH  operand 1 (rs): multiplicand or dividend.
- `B`  in  WIDTH  operand 2 (rt): multiplier or divisor.
- `HiWrite`  in  1  MTHI strobe.
- `LoWrite`  in  1  MTLO strobe.
- `Wd`  in  WIDTH  MTHI/MTLO data.
- `Busy`  out  1  high while an operation is in flight.
- `Done`  out  1  one-cycle pulse when HI/LO are updated by an operation.
- `Hi`  out  WIDTH  HI register, read combinationally from the flop.
- `Lo`  out  WIDTH  LO register, read combinationally from the flop.

## Operation
- The FSM has three states: IDLE, RUN, FIX.
- IDLE -> RUN on `Start`.
  - Latch |A| and |B| (magnitudes only when `Op[0]`=1).
  - Latch the result-sign flags: quotient/product sign = A[31]^B[31]; remainder sign = A[31].
  - Clear the partial HI:LO accumulator and load the counter with `WIDTH`.
- RUN, one iteration per cycle, decrementing the counter.
  - Multiply: if the accumulator LSB is 1, add the multiplicand to the upper half; then shift the accumulator right by 1.
  - Divide: shift the remainder:quotient pair left by 1, trial-subtract the divisor, and keep the result with quotient bit 1 if it is non-negative.
- RUN -> FIX when the counter reaches 1 and that iteration completes.
- FIX -> IDLE.
  - Apply two's-complement sign correction for the signed ops.
  - Write HI/LO: product high/low, or remainder/quotient.
  - Assert `Done` for the following cycle.
- MTHI/MTLO write `Wd` into HI/LO at the clock edge when in IDLE and `Start`=0.
  - `HiWrite` and `LoWrite` may both be set in the same cycle.
- Ignored requests:
  - `Start` in IDLE takes priority over `HiWrite`/`LoWrite` in the same cycle; the MT write is dropped.
  - `Start`, `HiWrite` and `LoWrite` are ignored while `Busy`=1.
- Divide by zero:
  - Unsigned: quotient = all ones, remainder = dividend.
  - Signed: compute on magnitudes, then apply sign correction. Examples: 7/0 gives Lo=0xFFFFFFFF, Hi=7; -7/0 gives Lo=0x00000001, Hi=0xFFFFFFF9.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives Lo=0x80000000, Hi=0.
- `Hi`/`Lo` keep their previous values during RUN. No partial results are visible until FIX.

## Timing
- Reset (`Resetn`=0, any time including mid-operation): state IDLE, `Busy`=0, `Done`=0, `Hi`=0, `Lo`=0, counter=0, accumulators=0. Takes effect immediately and asynchronously.
- Start accepted at edge E0:
  - `Busy`=1 from E0 until E(WIDTH+1).
  - RUN covers edges E1..E`WIDTH`.
  - FIX happens at E(WIDTH+1): `Hi`/`Lo` update, `Busy` falls, and `Done`=1 for exactly one cycle.
- Total latency: 33 cycles from Start edge to result for `WIDTH`=32.
- A new `Start` is accepted in the same cycle `Done` is high, since the FSM is already in IDLE.
- Operands `A`/`B` are sampled only at E0. They may change afterward.
- MT writes are visible on `Hi`/`Lo` the cycle after the strobe edge.

## Configuration
- `MDU_DIV_EN` defined:
  - The full unit is built, including the divider datapath and Op codes 10/11.
- `MDU_DIV_EN` undefined:
  - The divider logic is removed.
  - `Start` with `Op[1]`=1 is ignored: it stays in IDLE, `Busy`=0, no `Done`, and HI/LO are unchanged.
  - In that same cycle, `HiWrite`/`LoWrite` apply normally.
  - Multiply behaviour and timing are unchanged.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> `Hi`=0xFFFFFFFE, `Lo`=0x00000001; `Done` exactly 33 cycles after the Start edge; `Busy` high for 33 cycles.
- MULT -3 × 5 -> `Hi`=0xFFFFFFFF, `Lo`=0xFFFFFFF1. MULT 0x80000000 × 0x80000000 -> `Hi`=0x40000000, `Lo`=0.
- DIV -7 / 2 -> `Lo`=0xFFFFFFFD, `Hi`=0xFFFFFFFF. DIVU 10 / 0 -> `Lo`=0xFFFFFFFF, `Hi`=0x0000000A. DIV 0x80000000 / -1 -> `Lo`=0x80000000, `Hi`=0.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 in IDLE -> `Hi`/`Lo` show those values the next cycle. A second Start with MTHI during `Busy` -> ignored, and the first result is intact.
- Assert `Resetn`=0 at cycle 10 of a MULTU -> `Busy`, `Done`, `Hi`, `Lo` are all 0 immediately. After release, a new MULTU 6×7 -> `Lo`=42, `Hi`=0.
- With `MDU_DIV_EN` undefined: DIVU 10/2 Start -> `Busy` stays 0, no `Done`, `Hi`/`Lo` unchanged.

Source files
------------

// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative multiply/divide unit holding the architectural HI/LO pair.
// One shift-add (multiply) or restoring-subtract (divide) step per cycle,
// WIDTH steps per operation, then a sign-fix cycle that writes HI/LO.
// Build option: define MDU_DIV_EN to include the divider datapath (Op 10/11).
// With MDU_DIV_EN undefined, Start with Op[1]=1 is ignored.
module mdu_hilo #(
   parameter int WIDTH = 32
) (
   input  logic             Clock,
   input  logic             Resetn,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             HiWrite,
   input  logic             LoWrite,
   input  logic [WIDTH-1:0] Wd,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = {{(CW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t               state_q;
   logic [CW-1:0]        cnt_q;
   logic [2*WIDTH-1:0]   acc_q;     // {upper, lower}: product, or {remainder, quotient}
   logic [WIDTH-1:0]     opnd_q;    // multiplicand magnitude or divisor magnitude
   logic                 is_div_q;
   logic                 neg_q_q;   // product / quotient must be negated
   logic                 neg_r_q;   // remainder must be negated
   logic [WIDTH-1:0]     hi_q;
   logic [WIDTH-1:0]     lo_q;
   logic                 busy_q;
   logic                 done_q;

   logic                 start_ok_s;
   logic [WIDTH-1:0]     a_mag_s;
   logic [WIDTH-1:0]     b_mag_s;
   logic [2*WIDTH-1:0]   acc_d;
   logic [WIDTH:0]       mul_sum_s;
   logic [2*WIDTH:0]     mul_wide_s;
   logic [2*WIDTH-1:0]   prod_neg_s;
   logic [WIDTH-1:0]     fix_hi_s;
   logic [WIDTH-1:0]     fix_lo_s;

   // Two's-complement magnitude of x when the operation is signed.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
      if (sgn && x[WIDTH-1]) begin
         magnitude = -x;
      end else begin
         magnitude = x;
      end
   endfunction

   assign Busy = busy_q;
   assign Done = done_q;
   assign Hi   = hi_q;
   assign Lo   = lo_q;

   assign a_mag_s = magnitude(A, Op[0]);
   assign b_mag_s = magnitude(B, Op[0]);

   // Launch qualification: divide requests are dropped when the divider is not built.
   always_comb begin
`ifdef MDU_DIV_EN
      start_ok_s = Start;
`else
      start_ok_s = Start & ~Op[1];
`endif
   end

   // One iteration of the multiply or divide sequence on the accumulator.
   always_comb begin
      acc_d      = acc_q;
      mul_sum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
      mul_wide_s = {mul_sum_s, acc_q[WIDTH-1:0]};
      if (!is_div_q) begin
         if (acc_q[0]) begin
            acc_d = mul_wide_s[2*WIDTH:1];
         end else begin
            acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
         end
      end else begin
`ifdef MDU_DIV_EN
         // The shifted remainder can reach WIDTH+1 bits, so compare on that width.
         logic [WIDTH:0] rem_sh_s;
         logic [WIDTH:0] trial_s;
         rem_sh_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
         trial_s  = rem_sh_s - {1'b0, opnd_q};
         if (rem_sh_s >= {1'b0, opnd_q}) begin
            acc_d = {trial_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
         end else begin
            acc_d = {rem_sh_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
         end
`else
         acc_d = acc_q;
`endif
      end
   end

   // Sign correction of the finished accumulator into HI/LO values.
   always_comb begin
      prod_neg_s = -acc_q;
      fix_hi_s   = acc_q[2*WIDTH-1:WIDTH];
      fix_lo_s   = acc_q[WIDTH-1:0];
      if (!is_div_q) begin
         if (neg_q_q) begin
            fix_hi_s = prod_neg_s[2*WIDTH-1:WIDTH];
            fix_lo_s = prod_neg_s[WIDTH-1:0];
         end else begin
            fix_hi_s = acc_q[2*WIDTH-1:WIDTH];
            fix_lo_s = acc_q[WIDTH-1:0];
         end
      end else begin
         if (neg_q_q) begin
            fix_lo_s = -acc_q[WIDTH-1:0];
         end else begin
            fix_lo_s = acc_q[WIDTH-1:0];
         end
         if (neg_r_q) begin
            fix_hi_s = -acc_q[2*WIDTH-1:WIDTH];
         end else begin
            fix_hi_s = acc_q[2*WIDTH-1:WIDTH];
         end
      end
   end

   // Control FSM with registered Busy/Done and the HI/LO architectural registers.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q  <= S_IDLE;
         cnt_q    <= {CW{1'b0}};
         acc_q    <= {(2*WIDTH){1'b0}};
         opnd_q   <= {WIDTH{1'b0}};
         is_div_q <= 1'b0;
         neg_q_q  <= 1'b0;
         neg_r_q  <= 1'b0;
         hi_q     <= {WIDTH{1'b0}};
         lo_q     <= {WIDTH{1'b0}};
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_ok_s) begin
                  state_q  <= S_RUN;
                  busy_q   <= 1'b1;
                  cnt_q    <= CNT_INIT;
                  is_div_q <= Op[1];
                  neg_q_q  <= Op[0] & (A[WIDTH-1] ^ B[WIDTH-1]);
                  neg_r_q  <= Op[0] & A[WIDTH-1];
                  if (Op[1]) begin
                     acc_q  <= {{WIDTH{1'b0}}, a_mag_s};
                     opnd_q <= b_mag_s;
                  end else begin
                     acc_q  <= {{WIDTH{1'b0}}, b_mag_s};
                     opnd_q <= a_mag_s;
                  end
               end else begin
                  if (HiWrite) begin
                     hi_q <= Wd;
                  end
                  if (LoWrite) begin
                     lo_q <= Wd;
                  end
               end
            end
            S_RUN: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q - CNT_LAST;
               if (cnt_q == CNT_LAST) begin
                  state_q <= S_FIX;
               end
            end
            S_FIX: begin
               hi_q    <= fix_hi_s;
               lo_q    <= fix_lo_s;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule
